fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the COEN122 datapath, directly upstream of `register_file`. It holds the program counter, drives the instruction-memory address and latches the returned word with its PC into the IF/ID register. It also splits that word into the opcode and the 6-bit `rd_addr`/`rs_addr`/`rt_addr` fields that feed the register file. It handles stall, branch/jump redirect and flush. It holds automatically in any cycle where writeback owns the register-file port.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/pc_reg.sv | 39 +++
 rtl/fetch_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the COEN122 datapath: instruction field bounds,
// the NOP encoding and the opcode set seen by decode.
package cpu_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int OPC_W  = 4;

  localparam int RD_HI  = 27;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 10;
  localparam int REG_W  = 6;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'b0000,
    OP_ST   = 4'b0011,
    OP_ADD  = 4'b0100,
    OP_INC  = 4'b0101,
    OP_NEG  = 4'b0110,
    OP_SUB  = 4'b0111,
    OP_J    = 4'b1000,
    OP_BRZ  = 4'b1001,
    OP_JM   = 4'b1010,
    OP_BRN  = 4'b1011,
    OP_LD   = 4'b1110,
    OP_SVPC = 4'b1111
  } opcode_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with its next-PC mux: reset > redirect > hold > step.
// Ports: clock, reset, redirect/redirect_pc, hold in; pc out.
module pc_reg #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  PC_STEP  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                hold,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_q;

  // Increment is truncated to PC_WIDTH, so the PC wraps at all-ones.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (!hold) begin
      pc_d = pc_q + PC_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID register; slices the latched word into fields.
// Ports: clock/reset, stall/redirect/wb_write ctl, imem bus, IF/ID + fields.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  PC_STEP  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                wb_write,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic                id_valid,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [31:0]         id_instr,
  output logic [OPC_W-1:0]    opcode,
  output logic [REG_W-1:0]    rd_addr,
  output logic [REG_W-1:0]    rs_addr,
  output logic [REG_W-1:0]    rt_addr
);

  // Register file ignores reads while writeback owns its port.
  logic hold;
  assign hold = stall | wb_write;

  logic [PC_WIDTH-1:0] pc;

  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold        (hold),
    .pc          (pc)
  );

  logic                id_valid_d, id_valid_q;
  logic [PC_WIDTH-1:0] id_pc_d, id_pc_q;
  logic [31:0]         id_instr_d, id_instr_q;

  // Redirect leaves id_pc alone; only valid and the word are squashed.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (redirect) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (!hold) begin
      id_valid_d = 1'b1;
      id_pc_d    = pc;
      id_instr_d = imem_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign imem_addr = pc;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign opcode    = id_instr_q[OPC_HI:OPC_LO];
  assign rd_addr   = id_instr_q[RD_HI:RD_LO];
  assign rs_addr   = id_instr_q[RS_HI:RS_LO];
  assign rt_addr   = id_instr_q[RT_HI:RT_LO];

endmodule
